// File: rtl/dsp_pipe_pkg.sv
// dsp_pipe_pkg: shared helpers (clog2, lane pack/unpack over a MAX_W-bit bus keyed on lane width)
package dsp_pipe_pkg;
  localparam int MAX_W = 1024;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic logic [MAX_W-1:0] lane_get(input logic [MAX_W-1:0] v, input int i, input int w);
    return (v >> (i * w)) & ~({MAX_W{1'b1}} << w);
  endfunction
  function automatic logic [MAX_W-1:0] lane_set(input logic [MAX_W-1:0] v, input int i, input int w, input logic [MAX_W-1:0] x);
    logic [MAX_W-1:0] m;
    m = ~({MAX_W{1'b1}} << w) << (i * w);
    return (v & ~m) | ((x << (i * w)) & m);
  endfunction
endpackage

// File: rtl/dsp_pipe_if.sv
// dsp_pipe_if: pipe bus; master drives ce/sclr/lat_sel/in_valid/data, slave returns mux_out/out_valid/primed/fill_cnt
interface dsp_pipe_if #(parameter int D_WIDTH = 18, parameter int LANES = 1, parameter int DEPTH = 2) ();
  localparam int LS_W = dsp_pipe_pkg::clog2(DEPTH + 1);
  logic ce, sclr, in_valid, out_valid, primed;
  logic [LS_W-1:0] lat_sel, fill_cnt;
  logic [LANES*D_WIDTH-1:0] data, mux_out;
  modport master(output ce, sclr, lat_sel, in_valid, data, input mux_out, out_valid, primed, fill_cnt);
  modport slave(input ce, sclr, lat_sel, in_valid, data, output mux_out, out_valid, primed, fill_cnt);
endinterface

// File: rtl/pipe_reg_cell.sv
// pipe_reg_cell: W-bit register; ports clk, rst (async), i_ce, i_sclr (sync, wins over ce), i_d -> o_q
module pipe_reg_cell #(parameter int W = 19) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_ce,
  input  logic         i_sclr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_q <= '0;
    else if (i_sclr) r_q <= '0;
    else if (i_ce) r_q <= i_d;
  assign o_q = r_q;
endmodule

// File: rtl/dsp_pipe_stage.sv
// dsp_pipe_stage: multi-lane register chain with run-time tap select; ports clk, rst (async), bus (dsp_pipe_if.slave)
module dsp_pipe_stage import dsp_pipe_pkg::*; #(
  parameter int D_WIDTH = 18,
  parameter int LANES   = 1,
  parameter int DEPTH   = 2
) (
  input logic        clk,
  input logic        rst,
  dsp_pipe_if.slave  bus
);
  localparam int LS_W = clog2(DEPTH + 1);
  logic [D_WIDTH:0]   w_tap [LANES][DEPTH+1];
  logic [LANES-1:0]   w_vld;
  logic [LS_W-1:0]    r_fill, w_sel;
  assign w_sel = (bus.lat_sel > LS_W'(DEPTH)) ? LS_W'(DEPTH) : bus.lat_sel;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_tap[l][0] = {bus.in_valid, bus.data[l*D_WIDTH +: D_WIDTH]};
    for (genvar k = 1; k <= DEPTH; k++) begin : g_stg
      pipe_reg_cell #(.W(D_WIDTH + 1)) u_cell (
        .clk    (clk),
        .rst    (rst),
        .i_ce   (bus.ce),
        .i_sclr (bus.sclr),
        .i_d    (w_tap[l][k-1]),
        .o_q    (w_tap[l][k])
      );
    end
    assign bus.mux_out[l*D_WIDTH +: D_WIDTH] = w_tap[l][w_sel][D_WIDTH-1:0];
    assign w_vld[l] = w_tap[l][w_sel][D_WIDTH];
  end
  // every lane carries an identical valid copy; reducing them keeps all copies live
  assign bus.out_valid = &w_vld;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_fill <= '0;
    else if (bus.sclr) r_fill <= '0;
    else if (bus.ce && r_fill != LS_W'(DEPTH)) r_fill <= r_fill + 1'b1;
  assign bus.fill_cnt = r_fill;
  assign bus.primed = (r_fill == LS_W'(DEPTH));
endmodule
